// File: rtl/fu_dispatch_pkg.sv
// Shared types and constants for the fu_dispatch request sequencer.
package fu_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int unsigned DEF_Y_W = 10;
    localparam int unsigned DEF_X_W = 8;

    // Result reported when functional_unit never answers.
    localparam logic [DEF_X_W-1:0] X_TIMEOUT_VAL = '1;

endpackage

// File: rtl/fu_dispatch_fifo.sv
// disp_fifo: synchronous request FIFO with registered occupancy count.
module disp_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/fu_dispatch.sv
// Serialising request sequencer in front of functional_unit.
// Optional watchdog on fu_done enabled by defining FU_DISPATCH_TIMEOUT_EN.
module fu_dispatch
    import fu_dispatch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned Y_W         = DEF_Y_W,
    parameter int unsigned X_W         = DEF_X_W,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Y_W-1:0] in_y,
    output logic           fu_start,
    output logic [Y_W-1:0] fu_y,
    input  logic           fu_done,
    input  logic [X_W-1:0] fu_x,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Y_W-1:0] out_y,
    output logic [X_W-1:0] out_x,
    output logic           busy,
    output logic           timeout_err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t         r_state;
    logic           r_fu_start;
    logic [Y_W-1:0] r_fu_y;
    logic           r_out_valid;
    logic [Y_W-1:0] r_out_y;
    logic [X_W-1:0] r_out_x;

    logic           w_push;
    logic           w_pop;
    logic [Y_W-1:0] w_head;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;

    disp_fifo #(
        .WIDTH (Y_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_y),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Issue only with a free output slot so a result always has somewhere to land.
    assign in_ready  = ~w_full;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = (r_state == IDLE) & ~w_empty & ~r_out_valid;
    assign busy      = (r_state != IDLE) | (w_count != '0);

    assign fu_start  = r_fu_start;
    assign fu_y      = r_fu_y;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_x     = r_out_x;

`ifdef FU_DISPATCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{TIMEOUT_CYC, X_TIMEOUT_VAL};
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fu_start  <= 1'b0;
            r_fu_y      <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_x     <= '0;
`ifdef FU_DISPATCH_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state    <= ISSUE;
                        r_fu_start <= 1'b1;
                        r_fu_y     <= w_head;
                    end
                end
                ISSUE: begin
                    r_fu_start <= 1'b0;
                    r_state    <= WAIT_DONE;
`ifdef FU_DISPATCH_TIMEOUT_EN
                    r_to_cnt   <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (fu_done) begin
                        r_out_x     <= fu_x;
                        r_out_y     <= r_fu_y;
                        r_out_valid <= 1'b1;
                        r_state     <= WAIT_LOW;
                    end
`ifdef FU_DISPATCH_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_out_x       <= {X_W{X_TIMEOUT_VAL[0]}};
                        r_out_y       <= r_fu_y;
                        r_out_valid   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_state       <= WAIT_LOW;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                WAIT_LOW: begin
                    // Guarantee a done falling edge before the next start.
                    if (!fu_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_dispatch.sv
// Self-checking bench for fu_dispatch with a behavioural functional_unit model.
module tb_fu_dispatch;

    localparam int unsigned Y_W   = 10;
    localparam int unsigned X_W   = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [Y_W-1:0] in_y;
    logic           fu_start;
    logic [Y_W-1:0] fu_y;
    logic           fu_done;
    logic [X_W-1:0] fu_x;
    logic           out_valid;
    logic           out_ready;
    logic [Y_W-1:0] out_y;
    logic [X_W-1:0] out_x;
    logic           busy;
    logic           timeout_err;

    always #5 clk = ~clk;

    fu_dispatch #(
        .FIFO_DEPTH  (DEPTH),
        .Y_W         (Y_W),
        .X_W         (X_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_y        (in_y),
        .fu_start    (fu_start),
        .fu_y        (fu_y),
        .fu_done     (fu_done),
        .fu_x        (fu_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_x       (out_x),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } res_t;

    typedef struct {
        logic [Y_W-1:0] y;
        int             lat;
        int             hold;
        logic [X_W-1:0] exp_x;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];

    int             m_lat    = 12;
    int             m_hold   = 1;
    bit             m_busy   = 1'b0;
    int             m_cnt    = 0;
    int             m_starts = 0;
    logic [Y_W-1:0] m_y      = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [X_W-1:0] model_x(input logic [Y_W-1:0] y);
        case (y)
            10'd550: return 8'd23;
            10'd800: return 8'd28;
            default: return y[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Functional unit: done m_lat edges after start, held m_hold edges; m_lat==0 never answers.
    initial begin
        logic s_rst, s_start, s_done;
        fu_done = 1'b0;
        fu_x    = '0;
        forever begin
            @(posedge clk);
            s_rst   = rst;
            s_start = fu_start;
            s_done  = fu_done;
            if (!s_rst && s_start) check("start_while_busy", 32'(m_busy | s_done), 0);
            #1;
            if (s_rst) begin
                m_busy  = 1'b0;
                m_cnt   = 0;
                fu_done = 1'b0;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == m_lat) begin
                    fu_done = 1'b1;
                    fu_x    = model_x(m_y);
                end else if (m_cnt >= m_lat + m_hold) begin
                    fu_done = 1'b0;
                    m_busy  = 1'b0;
                end
            end else if (s_start) begin
                m_starts++;
                if (m_lat > 0) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_y    = fu_y;
                end
            end
        end
    end

    // Scoreboard: every consumed result must match the oldest expected one.
    initial begin
        res_t e;
        forever begin
            @(posedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_y), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("res_y", 32'(out_y), 32'(e.y));
                    check("res_x", 32'(out_x), 32'(e.x));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [Y_W-1:0] y);
        int   n;
        res_t r;
        n = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("push_ready_timeout", 32'(in_ready), 1);
        end else begin
            r.y = y;
            r.x = (m_lat == 0) ? 8'hFF : model_x(y);
            exp_q.push_back(r);
            in_valid = 1'b1;
            in_y     = y;
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        ok = out_valid;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || fu_done || m_busy) && n < 2000) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    initial begin
        vec_t vecs[5];
        bit   ok;
        bit   stable;
        int   s0;
        int   n;

        vecs[0] = '{y: 10'd550,  lat: 12, hold: 1, exp_x: 8'd23};
        vecs[1] = '{y: 10'd800,  lat: 12, hold: 2, exp_x: 8'd28};
        vecs[2] = '{y: 10'd0,    lat: 5,  hold: 1, exp_x: 8'hA5};
        vecs[3] = '{y: 10'd1023, lat: 1,  hold: 3, exp_x: 8'h5A};
        vecs[4] = '{y: 10'd300,  lat: 2,  hold: 1, exp_x: 8'h89};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_fu_start",    32'(fu_start),    0);
        check("rst_fu_y",        32'(fu_y),        0);
        check("rst_out_valid",   32'(out_valid),   0);
        check("rst_out_y",       32'(out_y),       0);
        check("rst_out_x",       32'(out_x),       0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_in_ready",    32'(in_ready),    1);
        check("rst_busy",        32'(busy),        0);

        // Single requests: start is visible after edge T+1 and sampled by the unit at edge T+2.
        foreach (vecs[i]) begin
            m_lat  = vecs[i].lat;
            m_hold = vecs[i].hold;
            s0     = m_starts;
            push(vecs[i].y);
            check("start_not_early", 32'(fu_start), 0);
            tick();
            check("start_pulse", 32'(fu_start), 1);
            check("start_y",     32'(fu_y),     32'(vecs[i].y));
            tick();
            check("start_one_cycle", 32'(fu_start), 0);
            wait_out(ok);
            check("out_valid_seen", 32'(ok),    1);
            check("vec_out_y",      32'(out_y), 32'(vecs[i].y));
            check("vec_out_x",      32'(out_x), 32'(vecs[i].exp_x));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("out_clears", 32'(out_valid), 0);
            repeat (vecs[i].hold + 4) tick();
            check("one_start", 32'(m_starts - s0), 1);
        end

        // Back-to-back with a 2-cycle done pulse.
        m_lat     = 12;
        m_hold    = 2;
        out_ready = 1'b1;
        s0        = m_starts;
        push(10'd550);
        push(10'd800);
        wait_drain("b2b_drain");
        check("b2b_starts", 32'(m_starts - s0), 2);

        // Full FIFO with the output slot occupied.
        m_lat     = 3;
        m_hold    = 1;
        out_ready = 1'b0;
        s0        = m_starts;
        for (int k = 0; k < 5; k++) push(Y_W'(100 + k * 37));
        repeat (30) tick();
        check("full_in_ready",  32'(in_ready),        0);
        check("full_out_valid", 32'(out_valid),       1);
        check("full_busy",      32'(busy),            1);
        check("full_one_issue", 32'(m_starts - s0),   1);
        out_ready = 1'b1;
        push(10'd999);
        wait_drain("full_drain");
        check("full_starts", 32'(m_starts - s0), 6);

        // Output backpressure holds the result and blocks further issue.
        m_lat     = 4;
        out_ready = 1'b0;
        push(10'd300);
        wait_out(ok);
        check("bp_valid", 32'(ok), 1);
        push(10'd301);
        s0     = m_starts;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid !== 1'b1 || out_y !== 10'd300 || out_x !== 8'h89) stable = 1'b0;
        end
        check("bp_stable",   32'(stable),          1);
        check("bp_no_start", 32'(m_starts - s0),   0);
        out_ready = 1'b1;
        wait_drain("bp_drain");

        // Reset while waiting for done with two requests queued.
        m_lat = 30;
        push(10'd500);
        push(10'd501);
        push(10'd502);
        n = 0;
        while (!m_busy && n < 50) begin
            tick();
            n++;
        end
        check("mid_fu_running", 32'(m_busy), 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_fu_start",  32'(fu_start),  0);
        check("mid_fu_y",      32'(fu_y),      0);
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_out_y",     32'(out_y),     0);
        check("mid_out_x",     32'(out_x),     0);
        check("mid_busy",      32'(busy),      0);
        check("mid_in_ready",  32'(in_ready),  1);
        s0 = m_starts;
        ok = 1'b0;
        repeat (60) begin
            tick();
            if (out_valid) ok = 1'b1;
        end
        check("mid_no_result", 32'(ok),              0);
        check("mid_no_start",  32'(m_starts - s0),   0);

`ifdef FU_DISPATCH_TIMEOUT_EN
        // Unit never answers: result forced to all-ones after 16 cycles in WAIT_DONE.
        m_lat     = 0;
        out_ready = 1'b0;
        push(10'd100);
        n = 0;
        while (!fu_start && n < 10) begin
            tick();
            n++;
        end
        check("to_start", 32'(fu_start), 1);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n),           17);
        check("to_out_x",  32'(out_x),       32'hFF);
        check("to_out_y",  32'(out_y),       100);
        check("to_err",    32'(timeout_err), 1);
        out_ready = 1'b1;
        m_lat     = 12;
        m_hold    = 1;
        s0        = m_starts;
        push(10'd550);
        wait_drain("to_next_drain");
        check("to_next_start",  32'(m_starts - s0), 1);
        check("to_err_sticky",  32'(timeout_err),   1);
`else
        check("no_timeout_err", 32'(timeout_err), 0);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fu_dispatch.md
Name: fu_dispatch

Overview:
- Request sequencer placed directly upstream of functional_unit.
- Buffers y samples from a valid/ready stream and issues each one to functional_unit as a one-cycle start pulse with a stable y_input.
- Captures x_guess when done rises and presents the {y, x} pair on a valid/ready result port.
- Serialises requests, so functional_unit never sees start while it is busy.

Parameters:
- FIFO_DEPTH, 4, request queue depth (power of 2, ≥2)
- Y_W, 10, y width (matches functional_unit y_input)
- X_W, 8, x width (matches functional_unit x_guess)
- TIMEOUT_CYC, 64, max cycles waiting for fu_done (used only with the optional feature)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_y  in  Y_W  request operand
- fu_start  out  1  one-cycle start to functional_unit
- fu_y  out  Y_W  drives functional_unit y_input
- fu_done  in  1  functional_unit done
- fu_x  in  X_W  functional_unit x_guess
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_y  out  Y_W  operand echoed back
- out_x  out  X_W  captured result
- busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty
- timeout_err  out  1  sticky error flag (optional feature only; tied to 0 otherwise)

Behaviour:
- Reset (rst=1 at a posedge):
  - FIFO emptied; state=IDLE.
  - fu_start=0, fu_y=0, out_valid=0, out_y=0, out_x=0, timeout_err=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation drops any in-flight request; no result is produced for it.
- Input side:
  - in_ready = (count != FIFO_DEPTH), decoded from the registered count only. There is no combinational path from the pop.
  - A push and a pop in the same cycle are legal whenever the FIFO is not full; count is unchanged.
- FSM states: IDLE, ISSUE, WAIT_DONE, WAIT_LOW.
  - IDLE → ISSUE when FIFO non-empty and out_valid=0 (the output slot must be free before issuing).
  - ISSUE: lasts one cycle.
    - fu_start=1; fu_y = FIFO head; head is popped.
    - Then → WAIT_DONE.
  - WAIT_DONE: fu_start=0; fu_y held.
    - fu_done is sampled here only; a done that is high during ISSUE is ignored.
    - On fu_done=1: out_x←fu_x, out_y←fu_y, out_valid←1 (visible the next cycle), then → WAIT_LOW.
  - WAIT_LOW: → IDLE when fu_done=0. This guarantees a done falling edge before the next start.
- fu_y changes only on entry to ISSUE. It is stable from start until done falls.
- Latency: push accepted at edge T → fu_start high in cycle T+2 at the earliest.
- Output: out_valid holds, with out_y/out_x stable, until out_valid & out_ready. It clears on the following edge.
- Throughput: one request per functional_unit run plus 3 cycles overhead.
- Widths: FIFO count is clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: FU_DISPATCH_TIMEOUT_EN
- Defined:
  - A counter starts at 0 on entry to WAIT_DONE.
  - If it reaches TIMEOUT_CYC without fu_done: out_x ← all-ones, out_valid←1, timeout_err←1 (sticky until rst), state → WAIT_LOW.
- Undefined: no counter; WAIT_DONE waits indefinitely; timeout_err tied 0.

Decomposition:
- Package fu_dispatch_pkg:
  - state enum {IDLE, ISSUE, WAIT_DONE, WAIT_LOW}
  - default Y_W/X_W constants
  - X_TIMEOUT_VAL constant
- Sub-module disp_fifo: synchronous FIFO, parameterised width/depth, with push/pop/full/empty/count.
- The FSM and output slot stay in fu_dispatch.

Test Plan:
- Single request: rst high 2 cycles, then push y=550; bench functional_unit model asserts done 12 cycles after start with x=23 → fu_start exactly one cycle at T+2 with fu_y=550; out_valid with out_y=550, out_x=23; exactly one start seen.
- Back-to-back: push 550 then 800 on consecutive cycles; model holds done high 2 cycles → second fu_start only after done falls; results emitted in order (550,23), (800,28).
- Full FIFO: stall out_ready=0, push 6 values → in_ready=0 after FIFO full and out slot occupied; no drops; all 6 results emerge in order once out_ready=1.
- Output backpressure: out_ready=0 for 20 cycles after a result → out_x/out_y stable; no new fu_start until consumed.
- Reset mid-run: assert rst during WAIT_DONE with 2 queued requests → all outputs return to reset values the next cycle, FIFO empty, no result emitted afterwards.
- With FU_DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=16: model never asserts done → out_x=8'hFF, timeout_err=1 at cycle 16 of WAIT_DONE; the next request still dispatches.
